// File: rtl/button_encoder.sv
// button_encoder: synchronises, debounces and encodes the four game buttons
// into a 2-bit colour code with a one-cycle valid strobe per accepted press.
// Multi-button presses and presses made while disarmed produce a REJECT
// strobe instead. A new press requires a full release first.
module button_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN,
  input  logic       ENABLE,
  output logic [1:0] CODE,
  output logic       CODE_VALID,
  output logic [3:0] BTN_STABLE,
  output logic       REJECT
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LOCKOUT
  } state_t;

  logic [3:0]    btn_meta;
  logic [3:0]    btn_sync;
  logic [3:0]    sync_q;
  logic [CW-1:0] cnt;
  state_t        state;

  logic          is_none;
  logic          is_single;
  logic          is_multi;
  logic [1:0]    sel_code;

  // Two-flop synchroniser for the asynchronous button lines
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= BTN;
      btn_sync <= btn_meta;
    end
  end

  // Joint debounce of the whole vector; any bit change restarts the count
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q     <= '0;
      cnt        <= '0;
      BTN_STABLE <= '0;
    end else begin
      sync_q <= btn_sync;
      if (btn_sync != sync_q) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        BTN_STABLE <= sync_q;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Classify the debounced vector and encode the single-press colour
  always_comb begin
    is_none   = (BTN_STABLE == 4'b0000);
    is_single = !is_none && ((BTN_STABLE & (BTN_STABLE - 4'd1)) == 4'b0000);
    is_multi  = !is_none && !is_single;
    sel_code  = 2'd0;
    case (BTN_STABLE)
      4'b0001: sel_code = 2'd0;
      4'b0010: sel_code = 2'd1;
      4'b0100: sel_code = 2'd2;
      4'b1000: sel_code = 2'd3;
      default: sel_code = 2'd0;
    endcase
  end

  // Press FSM with registered strobes; CODE only updates on an accepted press
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      CODE       <= '0;
      CODE_VALID <= 1'b0;
      REJECT     <= 1'b0;
    end else begin
      CODE_VALID <= 1'b0;
      REJECT     <= 1'b0;
      case (state)
        IDLE: begin
          if (is_single && ENABLE) begin
            CODE       <= sel_code;
            CODE_VALID <= 1'b1;
            state      <= HELD;
          end else if (is_single || is_multi) begin
            REJECT <= 1'b1;
            state  <= LOCKOUT;
          end
        end
        HELD: begin
          if (is_none) state <= IDLE;
        end
        LOCKOUT: begin
          if (is_none) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_encoder.sv
// Testbench for button_encoder with DEBOUNCE_CYCLES=4. A behavioural model
// (window-of-samples debounce plus a "waiting for release" flag) predicts every
// output each cycle; scenario tasks also check pulse counts and codes directly.
module tb_button_encoder;

  localparam int unsigned D = 4;

  logic       CLK;
  logic       RST_N;
  logic [3:0] BTN;
  logic       ENABLE;
  logic [1:0] CODE;
  logic       CODE_VALID;
  logic [3:0] BTN_STABLE;
  logic       REJECT;

  int total = 0;
  int bad   = 0;

  button_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .BTN        (BTN),
    .ENABLE     (ENABLE),
    .CODE       (CODE),
    .CODE_VALID (CODE_VALID),
    .BTN_STABLE (BTN_STABLE),
    .REJECT     (REJECT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  // Stable vector = the synchronised value once D+1 consecutive synchronised
  // samples agree; sampled BTN reaches the "synchronised" point 2 edges later.
  logic [3:0] hist[$];
  logic [3:0] m_stable;
  logic [1:0] m_code;
  logic       m_valid;
  logic       m_reject;
  logic       m_wait;
  int         m_valid_cnt  = 0;
  int         m_reject_cnt = 0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hist.delete();
      for (int i = 0; i < int'(D) + 3; i++) hist.push_front(4'b0000);
      m_stable = 4'b0000;
      m_code   = 2'd0;
      m_valid  = 1'b0;
      m_reject = 1'b0;
      m_wait   = 1'b0;
    end else begin
      bit same;
      m_valid  = 1'b0;
      m_reject = 1'b0;
      if (!m_wait) begin
        if (m_stable != 4'b0000) begin
          m_wait = 1'b1;
          if ($countones(m_stable) == 1 && ENABLE) begin
            m_valid = 1'b1;
            for (int b = 0; b < 4; b++) if (m_stable[b]) m_code = 2'(b);
            m_valid_cnt++;
          end else begin
            m_reject = 1'b1;
            m_reject_cnt++;
          end
        end
      end else if (m_stable == 4'b0000) begin
        m_wait = 1'b0;
      end
      hist.push_front(BTN);
      if (hist.size() > int'(D) + 3) void'(hist.pop_back());
      same = 1'b1;
      for (int i = 2; i <= 2 + int'(D); i++) if (hist[i] != hist[2]) same = 1'b0;
      if (same) m_stable = hist[2];
    end
  end

  // ---------------- per-cycle trace tally ----------------
  logic chk_on = 1'b0;
  int   mis_cnt = 0;
  time  first_mis = 0;
  int   dut_valid_cnt  = 0;
  int   dut_reject_cnt = 0;

  always @(negedge CLK) begin
    if (chk_on) begin
      if (CODE !== m_code || CODE_VALID !== m_valid ||
          REJECT !== m_reject || BTN_STABLE !== m_stable) begin
        if (mis_cnt == 0) first_mis = $time;
        mis_cnt++;
      end
      if (CODE_VALID === 1'b1) dut_valid_cnt++;
      if (REJECT === 1'b1) dut_reject_cnt++;
    end
  end

  task automatic hold(input logic [3:0] b, input int n);
    @(negedge CLK);
    BTN = b;
    repeat (n - 1) @(negedge CLK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int lat;
    int m0;
    ENABLE = 1'b1;
    BTN = 4'b0100;
    repeat (3) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk_on = 1'b1;
    m0 = mis_cnt;
    total++;
    if ({CODE, CODE_VALID, REJECT, BTN_STABLE} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got code=%b valid=%b reject=%b stable=%b want all 0",
               CODE, CODE_VALID, REJECT, BTN_STABLE);
    end
    repeat (2) @(negedge CLK);
    total++;
    if ({CODE, CODE_VALID, REJECT, BTN_STABLE} !== 8'h00) begin
      bad++;
      $display("FAIL reset_held_outputs got code=%b valid=%b reject=%b stable=%b want all 0",
               CODE, CODE_VALID, REJECT, BTN_STABLE);
    end
    RST_N = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (CODE_VALID === 1'b1) begin
        lat = i;
        break;
      end
    end
    total++;
    if (lat < 6 || lat > 8) begin
      bad++;
      $display("FAIL reset_latency got %0d clocks want 7+-1", lat);
    end
    total++;
    if (CODE !== 2'd2) begin
      bad++;
      $display("FAIL reset_code got %0d want 2", CODE);
    end
    hold(4'b0000, 12);
    total++;
    if (mis_cnt - m0 !== 0) begin
      bad++;
      $display("FAIL reset_trace mismatches=%0d first at %0t want 0", mis_cnt - m0, first_mis);
    end
  endtask

  task automatic test_single_hold;
    int v0 = dut_valid_cnt;
    int r0 = dut_reject_cnt;
    ENABLE = 1'b1;
    hold(4'b0010, 20);
    total++;
    if (BTN_STABLE !== 4'b0010) begin
      bad++;
      $display("FAIL hold_stable got %b want 0010", BTN_STABLE);
    end
    hold(4'b0000, 12);
    total++;
    if (BTN_STABLE !== 4'b0000) begin
      bad++;
      $display("FAIL release_stable got %b want 0000", BTN_STABLE);
    end
    total++;
    if (dut_valid_cnt - v0 !== 1 || CODE !== 2'd1) begin
      bad++;
      $display("FAIL hold_single got pulses=%0d code=%0d want pulses=1 code=1",
               dut_valid_cnt - v0, CODE);
    end
    total++;
    if (dut_reject_cnt - r0 !== 0) begin
      bad++;
      $display("FAIL hold_reject got %0d want 0", dut_reject_cnt - r0);
    end
  endtask

  task automatic test_glitch;
    int v0 = dut_valid_cnt;
    int r0 = dut_reject_cnt;
    int nz = 0;
    ENABLE = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge CLK);
      if (BTN_STABLE !== 4'b0000) nz++;
      BTN = (c < 12 && ((c / 2) % 2 == 0)) ? 4'b1000 : 4'b0000;
    end
    total++;
    if (nz !== 0) begin
      bad++;
      $display("FAIL glitch_stable got %0d nonzero cycles want 0", nz);
    end
    total++;
    if (dut_valid_cnt - v0 !== 0 || dut_reject_cnt - r0 !== 0) begin
      bad++;
      $display("FAIL glitch_strobes got valid=%0d reject=%0d want 0/0",
               dut_valid_cnt - v0, dut_reject_cnt - r0);
    end
  endtask

  task automatic test_multi;
    int v0 = dut_valid_cnt;
    int r0 = dut_reject_cnt;
    ENABLE = 1'b1;
    hold(4'b0011, 10);
    total++;
    if (dut_reject_cnt - r0 !== 1 || dut_valid_cnt - v0 !== 0) begin
      bad++;
      $display("FAIL multi_reject got reject=%0d valid=%0d want 1/0",
               dut_reject_cnt - r0, dut_valid_cnt - v0);
    end
    hold(4'b0000, 12);
    hold(4'b0001, 10);
    hold(4'b0000, 12);
    total++;
    if (dut_valid_cnt - v0 !== 1 || CODE !== 2'd0 || dut_reject_cnt - r0 !== 1) begin
      bad++;
      $display("FAIL multi_rearm got valid=%0d code=%0d reject=%0d want 1/0/1",
               dut_valid_cnt - v0, CODE, dut_reject_cnt - r0);
    end
  endtask

  task automatic test_disarmed;
    int v0 = dut_valid_cnt;
    int r0 = dut_reject_cnt;
    ENABLE = 1'b0;
    hold(4'b0100, 10);
    ENABLE = 1'b1;
    hold(4'b0100, 5);
    hold(4'b0000, 12);
    total++;
    if (dut_reject_cnt - r0 !== 1 || dut_valid_cnt - v0 !== 0) begin
      bad++;
      $display("FAIL disarmed_first got reject=%0d valid=%0d want 1/0",
               dut_reject_cnt - r0, dut_valid_cnt - v0);
    end
    hold(4'b0100, 10);
    hold(4'b0000, 12);
    total++;
    if (dut_valid_cnt - v0 !== 1 || CODE !== 2'd2 || dut_reject_cnt - r0 !== 1) begin
      bad++;
      $display("FAIL disarmed_second got valid=%0d code=%0d reject=%0d want 1/2/1",
               dut_valid_cnt - v0, CODE, dut_reject_cnt - r0);
    end
  endtask

  task automatic test_staggered;
    int v0 = dut_valid_cnt;
    int r0 = dut_reject_cnt;
    ENABLE = 1'b1;
    hold(4'b0001, 10);
    total++;
    if (CODE !== 2'd0 || dut_valid_cnt - v0 !== 1) begin
      bad++;
      $display("FAIL stagger_first got code=%0d valid=%0d want 0/1", CODE, dut_valid_cnt - v0);
    end
    ENABLE = 1'b0;
    hold(4'b0101, 10);
    ENABLE = 1'b1;
    hold(4'b0000, 12);
    hold(4'b1000, 10);
    hold(4'b0000, 12);
    total++;
    if (dut_valid_cnt - v0 !== 2 || CODE !== 2'd3 || dut_reject_cnt - r0 !== 0) begin
      bad++;
      $display("FAIL stagger_total got valid=%0d code=%0d reject=%0d want 2/3/0",
               dut_valid_cnt - v0, CODE, dut_reject_cnt - r0);
    end
  endtask

  task automatic test_random;
    int m0  = mis_cnt;
    int v0  = dut_valid_cnt;
    int r0  = dut_reject_cnt;
    int mv0 = m_valid_cnt;
    int mr0 = m_reject_cnt;
    for (int s = 0; s < 300; s++) begin
      int unsigned r = $urandom_range(0, 9);
      logic [3:0] b;
      if (r < 3) b = 4'b0000;
      else if (r < 8) b = 4'b0001 << $urandom_range(0, 3);
      else b = 4'($urandom_range(1, 15));
      ENABLE = 1'($urandom_range(0, 3) != 0);
      hold(b, int'($urandom_range(1, 12)));
    end
    hold(4'b0000, 12);
    total++;
    if (mis_cnt - m0 !== 0) begin
      bad++;
      $display("FAIL random_trace mismatches=%0d first at %0t want 0", mis_cnt - m0, first_mis);
    end
    total++;
    if (dut_valid_cnt - v0 !== m_valid_cnt - mv0) begin
      bad++;
      $display("FAIL random_valid_count got %0d want %0d", dut_valid_cnt - v0, m_valid_cnt - mv0);
    end
    total++;
    if (dut_reject_cnt - r0 !== m_reject_cnt - mr0) begin
      bad++;
      $display("FAIL random_reject_count got %0d want %0d", dut_reject_cnt - r0, m_reject_cnt - mr0);
    end
  endtask

  task automatic test_trace;
    total++;
    if (mis_cnt !== 0) begin
      bad++;
      $display("FAIL full_trace mismatches=%0d first at %0t want 0", mis_cnt, first_mis);
    end
  endtask

  initial begin
    RST_N  = 1'b1;
    BTN    = 4'b0000;
    ENABLE = 1'b0;
    test_reset();
    test_single_hold();
    test_glitch();
    test_multi();
    test_disarmed();
    test_staggered();
    test_random();
    test_trace();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_encoder.md
Name: button_encoder

Overview:
- Front end for the four game buttons.
- Synchronises and debounces the raw button lines, then encodes a single clean press into a 2-bit colour code.
- Emits a one-cycle valid strobe per accepted press.
- Drives the game controller's IN / IN_VALID inputs. Multi-button presses and presses made while input is disarmed are swallowed, so the controller only ever sees one strobe per physical press.

Parameters:
- DEBOUNCE_CYCLES, 1000, consecutive clocks a synchronised button vector must hold unchanged before it is accepted (minimum 2).

Ports:
- CLK  input  1  system clock
- RST_N  input  1  asynchronous active-low reset
- BTN  input  4  raw active-high buttons, asynchronous to CLK; bit n = colour n
- ENABLE  input  1  1 = presses may be accepted (controller in input phase)
- CODE  output  2  encoded colour of last accepted press; to controller IN
- CODE_VALID  output  1  one-cycle strobe, CODE valid; to controller IN_VALID
- BTN_STABLE  output  4  debounced button vector, for LED feedback
- REJECT  output  1  one-cycle strobe when a press is discarded (multi-press or disarmed)

Behaviour:
- Reset (RST_N low, asynchronous):
  - CODE=0, CODE_VALID=0, REJECT=0, BTN_STABLE=0.
  - Synchroniser flops = 0, debounce counter = 0, state = IDLE.
  - Release is synchronous to CLK.
- Synchroniser: two flops per bit; sync = BTN delayed by 2 edges.
- Debounce:
  - Register sync_q holds the previous-cycle sync.
  - Counter width = clog2(DEBOUNCE_CYCLES).
  - If sync != sync_q: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: BTN_STABLE <= sync_q; counter holds (saturates).
  - Else: counter <= counter+1.
  - Whole 4-bit vector debounced jointly; any bit changing restarts the count.
  - Glitches shorter than DEBOUNCE_CYCLES never reach BTN_STABLE.
- Press classification (combinational on BTN_STABLE): none = 0000; single = exactly one bit set; multi = two or more bits set.
- FSM, registered, 3 states:
  - IDLE:
    - single & ENABLE: CODE <= index of set bit (0001->0, 0010->1, 0100->2, 1000->3); CODE_VALID <= 1; go HELD.
    - single & !ENABLE: REJECT <= 1; go LOCKOUT.
    - multi: REJECT <= 1; go LOCKOUT.
    - none: stay.
  - HELD:
    - none: go IDLE.
    - Additional buttons joining while held: no strobe, no REJECT, stay HELD.
  - LOCKOUT:
    - none: go IDLE.
    - Else stay; no strobes.
- CODE_VALID and REJECT default to 0 every cycle (pulse outputs); never high together.
- CODE holds its value between presses; it changes only on the cycle CODE_VALID is asserted.
- ENABLE is sampled only in IDLE. Dropping ENABLE while in HELD/LOCKOUT has no effect.
- Latency: a clean press on BTN at edge 0 gives CODE_VALID high after edge 2+DEBOUNCE_CYCLES+1 (±1 edge for asynchronous arrival). Release is processed with the same latency.
- Re-arm: a second press needs BTN_STABLE to pass through 0000 first. Holding a button yields exactly one strobe.
- Reset mid-press: state returns to IDLE and BTN_STABLE to 0. A button still held after reset re-debounces and is treated as a new press.
- Simultaneous presses landing in the same debounce window are a multi-press: rejected.
- Staggered press (second button arrives after the first is accepted): first accepted; second ignored until full release.

Test Plan:
- DEBOUNCE_CYCLES=4; RST_N low with BTN=0100 -> all outputs 0; after release, CODE_VALID pulses once, CODE=2, exactly 7±1 clocks after reset release.
- ENABLE=1; BTN=0010 held 20 clocks then released -> one CODE_VALID pulse with CODE=1; BTN_STABLE=0010 during hold, 0000 after release; state back to IDLE.
- ENABLE=1; BTN=1000 toggled every 2 clocks for 12 clocks, then 0 -> no CODE_VALID, no REJECT, BTN_STABLE stays 0000.
- ENABLE=1; BTN=0011 held 10 clocks -> REJECT pulses once, no CODE_VALID. After release, BTN=0001 -> CODE_VALID with CODE=0.
- ENABLE=0; BTN=0100 pressed. ENABLE rises while held, then button released, then BTN=0100 pressed again -> REJECT on the first press only; CODE_VALID with CODE=2 on the second.
- ENABLE=1; BTN=0001 accepted, then 0101 held, then 0000, then 1000 -> CODE_VALID pulses twice only (CODE=0 then CODE=3); no REJECT.
